// File: rtl/sobel_magnitude_ctrl.sv
// Sobel edge magnitude controller.
// Takes a signed gradient pair (gx, gy), squares both magnitudes with two
// bit-serial shift-add squarers, bypasses the trivial sums (zero and
// saturated), and otherwise hands the sum to an external square-root unit
// over a start/done handshake.
// The 8-bit result goes out on a valid/ready handshake.
// Optional build macro: MAG_TIMEOUT_EN adds a watchdog on the sqrt wait.
// When the watchdog fires, the block returns a saturated result and raises
// mag_err.
module sobel_magnitude_ctrl #(
  parameter int IN_W           = 11,
  parameter int MAG_W          = 8,
  parameter int SQ_W           = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  gx,
  input  logic [IN_W-1:0]  gy,
  output logic             sqrt_start,
  output logic [SQ_W-1:0]  sqrt_data,
  input  logic [MAG_W-1:0] sqrt_answer,
  input  logic             sqrt_done,
  output logic             mag_valid,
  input  logic             mag_ready,
  output logic [MAG_W-1:0] mag_out,
  output logic             mag_err
);

  localparam int PROD_W = 2 * IN_W - 1;  // |g|^2 of an IN_W-bit signed value
  localparam int SUM_W  = 2 * IN_W;      // sum of two squares, never overflows
  localparam int CNT_W  = $clog2(IN_W);
  localparam logic [SUM_W-1:0] SAT_SUM = SUM_W'((2**MAG_W - 1) * (2**MAG_W - 1));
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  // The watchdog needs room for at least one wait cycle before it fires.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQUARE,
    ST_SUM,
    ST_SQRT_WAIT,
    ST_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    mplier_x_q, mplier_x_d, mplier_y_q, mplier_y_d;
  logic [PROD_W-1:0]  mcand_x_q, mcand_x_d, mcand_y_q, mcand_y_d;
  logic [PROD_W-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sqrt_start_q, sqrt_start_d;
  logic [SQ_W-1:0]    sqrt_data_q, sqrt_data_d;
  logic [MAG_W-1:0]   mag_out_q, mag_out_d;
  logic               mag_err_q, mag_err_d;
  logic               in_ready_q, in_ready_d;
  logic               done_prev_q, done_prev_d;
  logic [SUM_W-1:0]   sum_w;
  logic               done_rise;
`ifdef MAG_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
`endif

  // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1).
  function automatic logic [IN_W-1:0] abs_val(input logic [IN_W-1:0] v);
    return v[IN_W-1] ? (~v + IN_W'(1)) : v;
  endfunction

  assign sum_w     = SUM_W'(acc_x_q) + SUM_W'(acc_y_q);
  assign done_rise = sqrt_done & ~done_prev_q;

  // Next-state and datapath updates for the whole pair lifecycle.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d      = state_q;
    mplier_x_d   = mplier_x_q;
    mplier_y_d   = mplier_y_q;
    mcand_x_d    = mcand_x_q;
    mcand_y_d    = mcand_y_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    bit_cnt_d    = bit_cnt_q;
    sqrt_start_d = sqrt_start_q;
    sqrt_data_d  = sqrt_data_q;
    mag_out_d    = mag_out_q;
    mag_err_d    = mag_err_q;
    done_prev_d  = sqrt_done;  // tracked in every state so a stale high done is never an edge
`ifdef MAG_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mplier_x_d = abs_val(gx);
          mplier_y_d = abs_val(gy);
          mcand_x_d  = PROD_W'(abs_val(gx));
          mcand_y_d  = PROD_W'(abs_val(gy));
          acc_x_d    = '0;
          acc_y_d    = '0;
          bit_cnt_d  = '0;
          state_d    = ST_SQUARE;
        end
      end

      ST_SQUARE: begin
        // One multiplier bit per cycle: add the shifted multiplicand when set.
        if (mplier_x_q[0]) acc_x_d = acc_x_q + mcand_x_q;
        if (mplier_y_q[0]) acc_y_d = acc_y_q + mcand_y_q;
        mcand_x_d  = mcand_x_q << 1;
        mcand_y_d  = mcand_y_q << 1;
        mplier_x_d = mplier_x_q >> 1;
        mplier_y_d = mplier_y_q >> 1;
        if (bit_cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = ST_SUM;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      ST_SUM: begin
        if (sum_w == '0) begin
          mag_out_d = '0;
          state_d   = ST_OUT;
        end else if (sum_w >= SAT_SUM) begin
          mag_out_d = MAG_MAX;
          state_d   = ST_OUT;
        end else begin
          sqrt_data_d  = sum_w[SQ_W-1:0];
          sqrt_start_d = 1'b1;
`ifdef MAG_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
          state_d      = ST_SQRT_WAIT;
        end
      end

      ST_SQRT_WAIT: begin
        if (done_rise) begin
          mag_out_d    = sqrt_answer;
          sqrt_start_d = 1'b0;
          state_d      = ST_OUT;
        end
`ifdef MAG_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          mag_out_d    = MAG_MAX;
          mag_err_d    = 1'b1;
          sqrt_start_d = 1'b0;
          state_d      = ST_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end

      ST_OUT: begin
        if (mag_ready) begin
          mag_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered so in_ready stays low while reset is held.
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset aborts any pair in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mplier_x_q   <= '0;
      mplier_y_q   <= '0;
      mcand_x_q    <= '0;
      mcand_y_q    <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      bit_cnt_q    <= '0;
      sqrt_start_q <= 1'b0;
      sqrt_data_q  <= '0;
      mag_out_q    <= '0;
      mag_err_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      done_prev_q  <= 1'b0;
`ifdef MAG_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q      <= state_d;
      mplier_x_q   <= mplier_x_d;
      mplier_y_q   <= mplier_y_d;
      mcand_x_q    <= mcand_x_d;
      mcand_y_q    <= mcand_y_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      bit_cnt_q    <= bit_cnt_d;
      sqrt_start_q <= sqrt_start_d;
      sqrt_data_q  <= sqrt_data_d;
      mag_out_q    <= mag_out_d;
      mag_err_q    <= mag_err_d;
      in_ready_q   <= in_ready_d;
      done_prev_q  <= done_prev_d;
`ifdef MAG_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign sqrt_start = sqrt_start_q;
  assign sqrt_data  = sqrt_data_q;
  assign mag_valid  = (state_q == ST_OUT);
  assign mag_out    = mag_out_q;
  assign mag_err    = mag_err_q;

endmodule

// File: doc/sobel_magnitude_ctrl.md
Name: sobel_magnitude_ctrl

Overview:
- Initiator side of the sqrt request/done interface. Accepts a signed Sobel gradient pair (gx, gy) and computes gx²+gy² with a sequential shift-add squarer.
- Saturates or bypasses trivial sums; otherwise issues the sum to the sqrt unit, waits for done, and returns an 8-bit edge magnitude over a valid/ready handshake.
- Sits between the Sobel convolution stage and the output pixel writer.

Parameters:
IN_W, 11, signed gradient width (range -1024..1023)
MAG_W, 8, magnitude width; saturation value 2^MAG_W-1 = 255
SQ_W, 20, width of sqrt_data
TIMEOUT_CYCLES, 64, sqrt watchdog limit (only with MAG_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  gradient pair valid
in_ready  out  1  block can accept a pair
gx  in  IN_W  signed horizontal gradient
gy  in  IN_W  signed vertical gradient
sqrt_start  out  1  request to sqrt unit
sqrt_data  out  SQ_W  radicand
sqrt_answer  in  MAG_W  sqrt result
sqrt_done  in  1  sqrt completion
mag_valid  out  1  magnitude valid
mag_ready  in  1  downstream accepts magnitude
mag_out  out  MAG_W  edge magnitude
mag_err  out  1  sqrt timeout flag (held 0 without MAG_TIMEOUT_EN)

Behaviour:
- Reset (async assert, sync deassert): state IDLE, in_ready=0 during reset then 1; sqrt_start=0, sqrt_data=0, mag_valid=0, mag_out=0, mag_err=0, counters=0. Reset mid-operation aborts the operation; no output is produced for it.
- States: IDLE, SQUARE, SUM, SQRT_WAIT, OUT.
- IDLE: in_ready=1. On in_valid&in_ready (cycle T0), latch |gx|, |gy| (11-bit unsigned; |-1024|=1024) and go to SQUARE.
- SQUARE: two parallel 11-iteration shift-add squarers, one bit per cycle, for cycles T0+1..T0+11. Products are 21 bits unsigned. Then go to SUM.
- SUM (T0+12): sum = ax²+ay², 22 bits, no overflow.
  - sum==0: mag_out=0, go to OUT.
  - sum>=(2^MAG_W-1)² = 65025: mag_out=255, go to OUT.
  - Otherwise: sqrt_data=sum[SQ_W-1:0], go to SQRT_WAIT.
  - In the bypass cases sqrt_start is never asserted.
- SQRT_WAIT: sqrt_start=1 and sqrt_data held stable. A registered copy of sqrt_done is kept; completion is a 0->1 transition of sqrt_done sampled in this state. A done already high on entry is ignored until it falls and rises again.
  - On completion: mag_out=sqrt_answer, sqrt_start=0 the next cycle, go to OUT.
  - sqrt_done activity in any other state is ignored.
- OUT: mag_valid=1. mag_out is stable until mag_valid&mag_ready. On acceptance, next cycle mag_valid=0 and state IDLE.
- in_ready=0 in every state except IDLE; one pair in flight at a time.
- Latency: bypass result is valid at T0+13. Sqrt path result is valid one cycle after the detected done edge.
- Throughput: minimum 14 cycles per pair (bypass, mag_ready held high).

Optional Feature:
MAG_TIMEOUT_EN
- Defined: a cycle counter runs in SQRT_WAIT. If no done edge is seen after TIMEOUT_CYCLES cycles: sqrt_start=0, mag_out=255, mag_err=1, go to OUT. mag_err clears with the mag_valid&mag_ready acceptance.
- Undefined: no counter; SQRT_WAIT waits indefinitely; mag_err is constant 0.

Test Plan:
- gx=120, gy=150; sqrt model returns floor sqrt -> sqrt_data=36900, mag_out=192, mag_err=0.
- gx=-180, gy=179 -> sqrt_data=64441, mag_out=253 (sign ignored).
- gx=1020, gy=1020, then gx=-1020, gy=-1020 -> mag_out=255 at T0+13 for each; sqrt_start never asserted.
- Boundaries:
  - gx=255, gy=0 -> sum 65025 -> 255 via bypass.
  - gx=254, gy=10 -> sum 64616 -> sqrt path -> 254.
  - gx=-1024, gy=0 -> 255.
  - gx=0, gy=0 -> 0 via bypass.
- Backpressure and reset:
  - Hold mag_ready=0 for 5 cycles in OUT -> mag_out stable; in_ready=0; a new in_valid is not accepted.
  - Assert reset_n=0 during SQRT_WAIT -> all outputs 0 immediately.
  - Next pair gx=3, gy=4 -> 5.
- With MAG_TIMEOUT_EN: sqrt model never raises done -> after 64 cycles in SQRT_WAIT, mag_out=255, mag_err=1, sqrt_start=0. A done edge arriving later is ignored.
